// File: rtl/alpha_norm_lifo.sv
// Alpha-metric normalizer and window LIFO for the SISO turbo decoder.
// Each accepted vector is min-subtracted and saturated, then the window is replayed newest-first.
module alpha_norm_lifo #(
  parameter int unsigned NUM_STATES = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned WIN_LEN    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_STATES*W-1:0]       in_alpha,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_STATES*W-1:0]       out_alpha,
  output logic                          out_last,
  output logic [W-1:0]                  norm_min,
  output logic                          sat_flag,
  output logic [$clog2(WIN_LEN+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(WIN_LEN + 1);
  localparam int unsigned AW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned VW = NUM_STATES * W;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state;
  logic [VW-1:0]       mem [WIN_LEN];
  logic signed [W-1:0] min_c;
  logic [W:0]          diff_c [NUM_STATES];
  logic [VW-1:0]       norm_c;
  logic                sat_c;
  logic                accept;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       rd_idx;

  // Signed minimum across all states of the incoming vector
  always_comb begin
    min_c = $signed(in_alpha[W-1:0]);
    for (int i = 1; i < NUM_STATES; i++) begin
      if ($signed(in_alpha[i*W +: W]) < min_c) min_c = $signed(in_alpha[i*W +: W]);
    end
  end

  // Subtract in W+1 bits; anything beyond the positive W-bit range clips to MAXV
  always_comb begin
    norm_c = '0;
    sat_c  = 1'b0;
    for (int i = 0; i < NUM_STATES; i++) begin
      diff_c[i] = {in_alpha[i*W+W-1], in_alpha[i*W +: W]} - {min_c[W-1], min_c};
      if (diff_c[i][W:W-1] != 2'b00) begin
        norm_c[i*W +: W] = MAXV;
        sat_c            = 1'b1;
      end else begin
        norm_c[i*W +: W] = diff_c[i][W-1:0];
      end
    end
  end

  assign in_ready  = !rst && (state == FILL);
  assign out_valid = !rst && (state == DRAIN);
  assign accept    = in_valid && in_ready;
  assign wr_idx    = AW'(count);
  assign rd_idx    = AW'(count - CW'(1));
  assign out_alpha = out_valid ? mem[rd_idx] : '0;
  assign out_last  = out_valid && (count == CW'(1));

  // Window storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= norm_c;
  end

  // Fill/drain control, occupancy and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      count    <= '0;
      norm_min <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            count    <= count + CW'(1);
            norm_min <= min_c;
            sat_flag <= sat_flag | sat_c;
            if (in_last || (count == CW'(WIN_LEN - 1))) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_norm_lifo.sv
// Randomized self-checking bench for alpha_norm_lifo against a queue-based reference model.
module tb_alpha_norm_lifo;

  localparam int NS = 8;
  localparam int W  = 8;
  localparam int WL = 16;
  localparam int VW = NS * W;
  localparam int CW = $clog2(WL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_alpha;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_alpha;
  logic          out_last;
  logic [W-1:0]  norm_min;
  logic          sat_flag;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  logic [VW-1:0] mq[$];
  bit sat_model = 1'b0;

  alpha_norm_lifo #(.NUM_STATES(NS), .W(W), .WIN_LEN(WL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alpha(in_alpha), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_alpha(out_alpha), .out_last(out_last),
    .norm_min(norm_min), .sat_flag(sat_flag), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input int a[NS]);
    logic [VW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*W +: W] = W'(a[i]);
    return v;
  endfunction

  // Reference: plain integer min, subtract and clip
  function automatic logic [VW-1:0] norm_ref(input logic [VW-1:0] v, output bit sat, output int mn);
    int n[NS];
    mn = $signed(v[W-1:0]);
    for (int i = 1; i < NS; i++) if ($signed(v[i*W +: W]) < mn) mn = $signed(v[i*W +: W]);
    sat = 1'b0;
    for (int i = 0; i < NS; i++) begin
      n[i] = $signed(v[i*W +: W]) - mn;
      if (n[i] > 127) begin n[i] = 127; sat = 1'b1; end
    end
    return pack(n);
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Stimulus only: present one vector for one edge and update the model
  task automatic push(input logic [VW-1:0] v, input bit last);
    bit s;
    int mn;
    in_valid = 1'b1; in_alpha = v; in_last = last;
    mq.push_back(norm_ref(v, s, mn));
    sat_model |= s;
    @(posedge clk); #1;
    in_valid = 1'b0; in_alpha = '0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_alpha = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
    tests++; if (out_alpha !== '0 || out_last !== 1'b0) begin fails++; $display("FAIL reset_out out_alpha=%h out_last=%b want 0 0", out_alpha, out_last); end
    tests++; if (count !== '0 || norm_min !== '0 || sat_flag !== 1'b0) begin fails++; $display("FAIL reset_state count=%0d norm_min=%0d sat=%b want 0 0 0", count, norm_min, sat_flag); end
    rst = 1'b0; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release in_ready=%b want 1", in_ready); end
    mq.delete(); sat_model = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int a[NS] = '{10, -5, 3, 0, 7, -5, 20, 1};
    int e[NS] = '{15, 0, 8, 5, 12, 0, 25, 6};
    logic [VW-1:0] exp_v;
    exp_v = pack(e);
    push(pack(a), 1'b1);
    void'(mq.pop_back());
    tests++; if (norm_min !== 8'hFB) begin fails++; $display("FAIL basic_min norm_min=%0d want -5", $signed(norm_min)); end
    tests++; if (out_valid !== 1'b1 || out_last !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL basic_hs out_valid=%b out_last=%b in_ready=%b want 1 1 0", out_valid, out_last, in_ready); end
    tests++; if (out_alpha !== exp_v) begin fails++; $display("FAIL basic_data got %h want %h", out_alpha, exp_v); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin fails++; $display("FAIL basic_refill out_valid=%b in_ready=%b count=%0d want 0 1 0", out_valid, in_ready, count); end
    // in_last without in_valid must not close anything
    in_last = 1'b1; @(posedge clk); #1; in_last = 1'b0;
    tests++; if (in_ready !== 1'b1 || count !== '0) begin fails++; $display("FAIL last_no_valid in_ready=%b count=%0d want 1 0", in_ready, count); end
  endtask

  task automatic test_saturation();
    int a[NS] = '{127, -128, 0, 0, 0, 0, 0, 0};
    int e[NS] = '{127, 0, 127, 127, 127, 127, 127, 127};
    logic [VW-1:0] exp_v;
    exp_v = pack(e);
    push(pack(a), 1'b1);
    void'(mq.pop_back());
    tests++; if (out_alpha !== exp_v) begin fails++; $display("FAIL sat_data got %h want %h", out_alpha, exp_v); end
    tests++; if (sat_flag !== 1'b1 || norm_min !== 8'h80) begin fails++; $display("FAIL sat_flag sat=%b min=%0d want 1 -128", sat_flag, $signed(norm_min)); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    push(rand_vec() & {NS{8'h0F}}, 1'b1);
    void'(mq.pop_back());
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_sticky sat=%b want 1", sat_flag); end
  endtask

  task automatic test_lifo_short();
    int a[NS];
    for (int s = 1; s <= 3; s++) begin
      for (int i = 0; i < NS; i++) a[i] = s * 10 + i * s;
      push(pack(a), s == 3);
    end
    for (int k = 3; k >= 1; k--) begin
      tests++; if (count !== CW'(k) || in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL lifo_hs k=%0d count=%0d in_ready=%b out_valid=%b", k, count, in_ready, out_valid); end
      tests++; if (out_alpha !== mq[$] || out_last !== (k == 1)) begin fails++; $display("FAIL lifo_data k=%0d got %h last=%b want %h last=%b", k, out_alpha, out_last, mq[$], k == 1); end
      void'(mq.pop_back());
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
    tests++; if (count !== '0 || in_ready !== 1'b1) begin fails++; $display("FAIL lifo_end count=%0d in_ready=%b want 0 1", count, in_ready); end
  endtask

  task automatic test_full_window();
    for (int s = 0; s < WL; s++) begin
      if (s == WL - 1) begin
        tests++; if (in_ready !== 1'b1 || count !== CW'(WL - 1)) begin fails++; $display("FAIL full_pre in_ready=%b count=%0d want 1 %0d", in_ready, count, WL - 1); end
      end
      push(rand_vec(), 1'b0);
    end
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || count !== CW'(WL)) begin fails++; $display("FAIL full_hs in_ready=%b out_valid=%b count=%0d want 0 1 %0d", in_ready, out_valid, count, WL); end
    out_ready = 1'b1;
    for (int k = WL; k >= 1; k--) begin
      tests++; if (out_alpha !== mq[$] || out_last !== (k == 1) || count !== CW'(k)) begin fails++; $display("FAIL full_drain k=%0d got %h last=%b cnt=%0d want %h", k, out_alpha, out_last, count, mq[$]); end
      void'(mq.pop_back());
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || count !== '0) begin fails++; $display("FAIL full_end out_valid=%b count=%0d want 0 0", out_valid, count); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    for (int s = 0; s < 4; s++) push(rand_vec(), s == 3);
    held = out_alpha;
    tests++; if (held !== mq[$]) begin fails++; $display("FAIL bp_first got %h want %h", held, mq[$]); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_alpha = rand_vec();
      @(posedge clk); #1;
      tests++; if (out_alpha !== held || out_last !== 1'b0 || count !== CW'(4) || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold c=%0d got %h last=%b cnt=%0d", c, out_alpha, out_last, count); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      tests++; if (out_alpha !== mq[$] || out_last !== (k == 1)) begin fails++; $display("FAIL bp_drain k=%0d got %h want %h", k, out_alpha, mq[$]); end
      void'(mq.pop_back());
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int len;
    int budget;
    bit rdy;
    bit s;
    int mn;
    logic [VW-1:0] v;
    for (int w = 0; w < 12; w++) begin
      len = $urandom_range(1, WL);
      for (int s2 = 0; s2 < len; s2++) begin
        v = rand_vec();
        push(v, (s2 == len - 1) ? ((len < WL) ? 1'b1 : 1'($urandom)) : 1'b0);
        void'(norm_ref(v, s, mn));
        tests++; if ($signed(norm_min) !== mn || sat_flag !== sat_model) begin fails++; $display("FAIL rnd_min w=%0d got %0d sat=%b want %0d sat=%b", w, $signed(norm_min), sat_flag, mn, sat_model); end
      end
      budget = 0;
      while (mq.size() > 0 && budget < 200) begin
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_alpha !== mq[$] || out_last !== (mq.size() == 1) || count !== CW'(mq.size())) begin
          fails++; $display("FAIL rnd_drain w=%0d got %h last=%b cnt=%0d want %h cnt=%0d", w, out_alpha, out_last, count, mq[$], mq.size());
        end
        rdy = 1'($urandom);
        out_ready = rdy; in_valid = 1'($urandom); in_alpha = rand_vec(); in_last = 1'($urandom);
        @(posedge clk); #1;
        if (rdy) void'(mq.pop_back());
        budget++;
      end
      out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      tests++; if (mq.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin fails++; $display("FAIL rnd_end w=%0d left=%0d out_valid=%b in_ready=%b", w, mq.size(), out_valid, in_ready); end
      mq.delete();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int s = 0; s < 7; s++) push(rand_vec(), s == 6);
    tests++; if (count !== CW'(7) || out_valid !== 1'b1) begin fails++; $display("FAIL rmd_pre count=%0d out_valid=%b want 7 1", count, out_valid); end
    rst = 1'b1; #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_alpha !== '0 || out_last !== 1'b0) begin fails++; $display("FAIL rmd_during in_ready=%b out_valid=%b out_alpha=%h", in_ready, out_valid, out_alpha); end
    @(posedge clk); #1;
    tests++; if (count !== '0 || sat_flag !== 1'b0 || norm_min !== '0) begin fails++; $display("FAIL rmd_state count=%0d sat=%b min=%0d want 0 0 0", count, sat_flag, norm_min); end
    rst = 1'b0; mq.delete(); sat_model = 1'b0; #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rmd_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    for (int s = 0; s < 3; s++) push(rand_vec(), s == 2);
    out_ready = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      tests++; if (out_alpha !== mq[$] || out_last !== (k == 1) || count !== CW'(k)) begin fails++; $display("FAIL rmd_fresh k=%0d got %h want %h", k, out_alpha, mq[$]); end
      void'(mq.pop_back());
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests++; if (sat_flag !== sat_model || count !== '0) begin fails++; $display("FAIL rmd_end sat=%b count=%0d want %b 0", sat_flag, count, sat_model); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_lifo_short();
    test_full_window();
    test_backpressure();
    test_random();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
